// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    RAM_WAIT,
    STDIN_WAIT,
    STDOUT_WAIT
  } hazard_state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_wait_counter.sv
// Loadable down-counter with zero flag; counts out the RAM read latency.
module hazard_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (load)               count <= load_value;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: EX waits, load-use bubbles, redirect flushes.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int RAM_READ_LATENCY = 2,
  parameter int WAIT_CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1_address,
  input  logic [4:0] id_rs2_address,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd_address,
  input  logic       ex_ram_read,
  input  logic       ex_stdin_read_enable,
  input  logic       ex_stdout_write_enable,
  input  logic       ex_redirect,
  input  logic       stdin_valid,
  input  logic       stdout_ready,
  output logic       pc_write_enable,
  output logic       if_id_write_enable,
  output logic       if_id_flush,
  output logic       id_ex_write_enable,
  output logic       id_ex_flush,
  output logic       ex_mem_write_enable,
  output logic       stdin_read_ack,
  output logic       busy
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_freeze_cycles,
  output logic [31:0] perf_bubble_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  localparam bit RAM_WAITS = (RAM_READ_LATENCY > 1);
  localparam int LOAD_VAL  = RAM_WAITS ? RAM_READ_LATENCY - 2 : 0;

  hazard_state_t         state, next_state;
  logic                  freeze, ack, cnt_load, cnt_dec, cnt_zero, load_use;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  hazard_wait_counter #(.W(WAIT_CNT_W)) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (WAIT_CNT_W'(LOAD_VAL)),
    .dec        (cnt_dec),
    .count      (wait_cnt),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    freeze     = 1'b0;
    ack        = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_ram_read && RAM_WAITS) begin
          freeze     = 1'b1;
          cnt_load   = 1'b1;
          next_state = RAM_WAIT;
        end else if (ex_ram_read) begin
          freeze = 1'b0;
        end else if (ex_stdin_read_enable) begin
          if (stdin_valid) ack = 1'b1;
          else begin
            freeze     = 1'b1;
            next_state = STDIN_WAIT;
          end
        end else if (ex_stdout_write_enable && !stdout_ready) begin
          freeze     = 1'b1;
          next_state = STDOUT_WAIT;
        end
      end
      RAM_WAIT: begin
        if (!cnt_zero) begin
          freeze  = 1'b1;
          cnt_dec = 1'b1;
        end else next_state = RUN;
      end
      STDIN_WAIT: begin
        if (stdin_valid) begin
          ack        = 1'b1;
          next_state = RUN;
        end else freeze = 1'b1;
      end
      STDOUT_WAIT: begin
        if (stdout_ready) next_state = RUN;
        else              freeze     = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  assign load_use = ex_ram_read && (ex_rd_address != ZERO_REG) &&
                    ((id_uses_rs1 && id_rs1_address == ex_rd_address) ||
                     (id_uses_rs2 && id_rs2_address == ex_rd_address));

  // Waits gate everything; redirect then beats load-use on the unfrozen cycle.
  always_comb begin
    pc_write_enable     = 1'b0;
    if_id_write_enable  = 1'b0;
    if_id_flush         = 1'b0;
    id_ex_write_enable  = 1'b0;
    id_ex_flush         = 1'b0;
    ex_mem_write_enable = 1'b0;
    stdin_read_ack      = 1'b0;
    busy                = 1'b0;
    if (!reset) begin
      busy           = (state != RUN);
      stdin_read_ack = ack;
      if (!freeze) begin
        id_ex_write_enable  = 1'b1;
        ex_mem_write_enable = 1'b1;
        if (ex_redirect) begin
          pc_write_enable    = 1'b1;
          if_id_write_enable = 1'b1;
          if_id_flush        = 1'b1;
          id_ex_flush        = 1'b1;
        end else if (load_use) begin
          id_ex_flush = 1'b1;
        end else begin
          pc_write_enable    = 1'b1;
          if_id_write_enable = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_freeze_cycles <= '0;
      perf_bubble_cycles <= '0;
      perf_flush_events  <= '0;
    end else begin
      if (freeze)                             perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
      if (!freeze && !ex_redirect && load_use) perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
      if (!freeze && ex_redirect)             perf_flush_events  <= perf_flush_events + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: one DUT with single-cycle RAM, one with 3-cycle RAM, shared reset.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ram;
    logic       sin;
    logic       sout;
    logic       redir;
    logic       sv;
    logic       sr;
  } in_t;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ack, busy}
  typedef struct packed {
    logic pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, ack, busy;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  typedef struct {
    string name;
    bit    d3;
    out_t  exp;
  } sb_t;

  localparam out_t E_ZERO  = 8'b000000_00;
  localparam out_t E_BUSY  = 8'b000000_01;
  localparam out_t E_RUN   = 8'b110101_00;
  localparam out_t E_REL   = 8'b110101_01;
  localparam out_t E_ACK   = 8'b110101_10;
  localparam out_t E_ACKB  = 8'b110101_11;
  localparam out_t E_LU    = 8'b000111_00;
  localparam out_t E_LUB   = 8'b000111_01;
  localparam out_t E_RD    = 8'b111111_00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  in_t  in1 = '0;
  in_t  in3 = '0;
  out_t o1, o3;
  int   checks = 0;
  int   passes = 0;
  sb_t  sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.RAM_READ_LATENCY(1), .WAIT_CNT_W(4)) u_lat1 (
    .clk(clk), .reset(reset),
    .id_rs1_address(in1.rs1), .id_rs2_address(in1.rs2),
    .id_uses_rs1(in1.u1), .id_uses_rs2(in1.u2),
    .ex_rd_address(in1.rd), .ex_ram_read(in1.ram),
    .ex_stdin_read_enable(in1.sin), .ex_stdout_write_enable(in1.sout),
    .ex_redirect(in1.redir), .stdin_valid(in1.sv), .stdout_ready(in1.sr),
    .pc_write_enable(o1.pc_we), .if_id_write_enable(o1.ifid_we), .if_id_flush(o1.ifid_fl),
    .id_ex_write_enable(o1.idex_we), .id_ex_flush(o1.idex_fl),
    .ex_mem_write_enable(o1.exmem_we), .stdin_read_ack(o1.ack), .busy(o1.busy)
  );

  pipeline_hazard_controller #(.RAM_READ_LATENCY(3), .WAIT_CNT_W(4)) u_lat3 (
    .clk(clk), .reset(reset),
    .id_rs1_address(in3.rs1), .id_rs2_address(in3.rs2),
    .id_uses_rs1(in3.u1), .id_uses_rs2(in3.u2),
    .ex_rd_address(in3.rd), .ex_ram_read(in3.ram),
    .ex_stdin_read_enable(in3.sin), .ex_stdout_write_enable(in3.sout),
    .ex_redirect(in3.redir), .stdin_valid(in3.sv), .stdout_ready(in3.sr),
    .pc_write_enable(o3.pc_we), .if_id_write_enable(o3.ifid_we), .if_id_flush(o3.ifid_fl),
    .id_ex_write_enable(o3.idex_we), .id_ex_flush(o3.idex_fl),
    .ex_mem_write_enable(o3.exmem_we), .stdin_read_ack(o3.ack), .busy(o3.busy)
  );

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else passes++;
  endtask

  task automatic push(input string name, input bit d3, input out_t exp);
    sb_t s;
    s.name = name;
    s.d3   = d3;
    s.exp  = exp;
    sb.push_back(s);
  endtask

  // Called at a falling edge after inputs are driven; samples mid-cycle, returns at the next falling edge.
  task automatic tick();
    sb_t s;
    #2;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      check(s.name, s.d3 ? o3 : o1, s.exp);
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"idle",          '{default: '0}, E_RUN};
    vecs[1] = '{"lu_rs1",        '{rs1: 5'd5, u1: 1'b1, rd: 5'd5, ram: 1'b1, default: '0}, E_LU};
    vecs[2] = '{"lu_rd0",        '{rs1: 5'd0, u1: 1'b1, rd: 5'd0, ram: 1'b1, default: '0}, E_RUN};
    vecs[3] = '{"lu_rs2",        '{rs2: 5'd9, u2: 1'b1, rd: 5'd9, ram: 1'b1, default: '0}, E_LU};
    vecs[4] = '{"lu_rs2_unused", '{rs2: 5'd9, u2: 1'b0, rd: 5'd9, ram: 1'b1, default: '0}, E_RUN};
    vecs[5] = '{"redir_lu",      '{rs1: 5'd5, u1: 1'b1, rd: 5'd5, ram: 1'b1, redir: 1'b1, default: '0}, E_RD};
    vecs[6] = '{"redir",         '{redir: 1'b1, default: '0}, E_RD};
    vecs[7] = '{"stdin_ready",   '{sin: 1'b1, sv: 1'b1, default: '0}, E_ACK};
    vecs[8] = '{"stdout_ready",  '{sout: 1'b1, sr: 1'b1, default: '0}, E_RUN};
    vecs[9] = '{"load_nodep",    '{rs1: 5'd4, u1: 1'b1, rd: 5'd5, ram: 1'b1, default: '0}, E_RUN};

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push("reset_lat1", 1'b0, E_ZERO);
      push("reset_lat3", 1'b1, E_ZERO);
      tick();
    end
    reset = 1'b0;
    push("release_lat1", 1'b0, E_RUN);
    push("release_lat3", 1'b1, E_RUN);
    tick();

    for (int i = 0; i < 10; i++) begin
      in1 = vecs[i].in;
      push(vecs[i].name, 1'b0, vecs[i].exp);
      tick();
    end
    in1 = '0;

    // Three-cycle RAM read, no dependent.
    in3 = '{ram: 1'b1, rd: 5'd7, default: '0};
    push("ram_issue", 1'b1, E_ZERO);  tick();
    push("ram_wait",  1'b1, E_BUSY);  tick();
    push("ram_rel",   1'b1, E_REL);   tick();
    in3 = '0;
    push("ram_after", 1'b1, E_RUN);   tick();

    // Load-use deferred to the release cycle.
    in3 = '{ram: 1'b1, rd: 5'd5, rs1: 5'd5, u1: 1'b1, default: '0};
    push("ramlu_issue", 1'b1, E_ZERO); tick();
    push("ramlu_wait",  1'b1, E_BUSY); tick();
    push("ramlu_rel",   1'b1, E_LUB);  tick();
    in3 = '0;
    push("ramlu_after", 1'b1, E_RUN);  tick();

    // Stdin: four frozen cycles then one ack cycle.
    in3 = '{sin: 1'b1, sv: 1'b0, default: '0};
    push("stdin_f0", 1'b1, E_ZERO); tick();
    for (int i = 1; i < 4; i++) begin
      push("stdin_wait", 1'b1, E_BUSY);
      tick();
    end
    in3.sv = 1'b1;
    push("stdin_rel", 1'b1, E_ACKB); tick();
    in3 = '0;
    push("stdin_after", 1'b1, E_RUN); tick();

    // Stdout: normal release.
    in3 = '{sout: 1'b1, sr: 1'b0, default: '0};
    push("stdout_f0",   1'b1, E_ZERO); tick();
    push("stdout_wait", 1'b1, E_BUSY); tick();
    in3.sr = 1'b1;
    push("stdout_rel",  1'b1, E_REL);  tick();
    in3 = '0;

    // Stdout: reset aborts the wait.
    in3 = '{sout: 1'b1, sr: 1'b0, default: '0};
    push("stdout2_f0",   1'b1, E_ZERO); tick();
    push("stdout2_wait", 1'b1, E_BUSY); tick();
    reset = 1'b1;
    push("stdout2_reset", 1'b1, E_ZERO); tick();
    reset = 1'b0;
    in3 = '0;
    push("post_reset", 1'b1, E_RUN); tick();
    push("post_reset2", 1'b1, E_RUN); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
